pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the in-order RISC-V core. It replaces the fixed stall/flush wiring, in which EX/MEM stall and flush are tied to 0. It tracks per-stage valid bits, generates per-register load enables and flushes, and inserts bubbles for variable-latency imem/dmem, load-use hazards and branch redirects. Sits beside hazard_unit in the core top; the datapath stages consume its enables.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl_perf_cnt.sv | 42 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline control unit.
//   stall_cause_e - which hazard (if any) holds the front of the pipeline
//   IF..WB        - default stage indices of the 5-stage core
//   PERF_*        - optional performance-counter bank size and slot indices
//   freeze_index  - highest register index held for a given stall cause
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_IMEM,
        STALL_LOADUSE,
        STALL_DMEM
    } stall_cause_e;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

    localparam int PERF_NUM           = 6;
    localparam int PERF_CYCLE         = 0;
    localparam int PERF_RETIRED       = 1;
    localparam int PERF_STALL_IMEM    = 2;
    localparam int PERF_STALL_LOADUSE = 3;
    localparam int PERF_STALL_DMEM    = 4;
    localparam int PERF_REDIRECT      = 5;

    // Registers 1..freeze_index hold; the one above it receives a bubble.
    function automatic int unsigned freeze_index(stall_cause_e cause,
                                                 int unsigned  haz_stage,
                                                 int unsigned  mem_stage);
        case (cause)
            STALL_DMEM:    return mem_stage;
            STALL_LOADUSE: return haz_stage;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: control bundle between the core datapath/hazard unit and
// pipe_ctrl.
//   master modport - datapath side: drives status, consumes enables
//   slave modport  - pipe_ctrl side
// Signals:
//   imem_ready_i, dmem_busy_i, load_use_i, redirect_i   status into pipe_ctrl
//   pc_en_o, pc_sel_redirect_o                           PC control
//   stage_valid_o/stage_en_o/stage_flush_o [NUM_STAGES]  per-register control
//   retire_o, mem_timeout_o                              commit / sticky error
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 5
);
    logic                  imem_ready_i;
    logic                  dmem_busy_i;
    logic                  load_use_i;
    logic                  redirect_i;
    logic                  pc_en_o;
    logic                  pc_sel_redirect_o;
    logic [NUM_STAGES-1:0] stage_valid_o;
    logic [NUM_STAGES-1:0] stage_en_o;
    logic [NUM_STAGES-1:0] stage_flush_o;
    logic                  retire_o;
    logic                  mem_timeout_o;

    modport master (
        output imem_ready_i, dmem_busy_i, load_use_i, redirect_i,
        input  pc_en_o, pc_sel_redirect_o, stage_valid_o, stage_en_o,
               stage_flush_o, retire_o, mem_timeout_o
    );

    modport slave (
        input  imem_ready_i, dmem_busy_i, load_use_i, redirect_i,
        output pc_en_o, pc_sel_redirect_o, stage_valid_o, stage_en_o,
               stage_flush_o, retire_o, mem_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_perf_cnt: bank of 32-bit wrapping event counters for pipe_ctrl.
// Present only when PIPE_CTRL_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (only clear source)
//   retire_i     instruction committed this cycle
//   redirect_i   honoured redirect this cycle
//   cause_i      effective stall cause this cycle
//   cnt_o        counters, indexed by PERF_* slots
`ifdef PIPE_CTRL_PERF_CNT_EN
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         retire_i,
    input  logic         redirect_i,
    input  stall_cause_e cause_i,
    output logic [31:0]  cnt_o [PERF_NUM]
);
    logic [PERF_NUM-1:0] inc;

    always_comb begin
        inc                     = '0;
        inc[PERF_CYCLE]         = 1'b1;
        inc[PERF_RETIRED]       = retire_i;
        inc[PERF_STALL_IMEM]    = (cause_i == STALL_IMEM);
        inc[PERF_STALL_LOADUSE] = (cause_i == STALL_LOADUSE);
        inc[PERF_STALL_DMEM]    = (cause_i == STALL_DMEM);
        inc[PERF_REDIRECT]      = redirect_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PERF_NUM; i++) cnt_o[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < PERF_NUM; i++) begin
                if (inc[i]) cnt_o[i] <= cnt_o[i] + 32'd1;
            end
        end
    end
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the in-order RISC-V core. Tracks
// per-register valid bits and generates load enables, flushes and bubbles
// for imem/dmem wait states, load-use hazards and branch redirects.
// Ports:
//   clk, rst_n  core clock / asynchronous active-low reset
//   ctrl        pipe_ctrl_if.slave control bundle
//   perf_cnt_o  [PERF_NUM][32] event counters (PIPE_CTRL_PERF_CNT_EN only)
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN
// Parameter constraints: 4 <= NUM_STAGES <= 8,
//   HAZ_STAGE < REDIRECT_STAGE < MEM_STAGE <= NUM_STAGES-2 (last stage never
//   stalls). MEM_TIMEOUT = 0 disables the dmem timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = WB + 1,
    parameter int HAZ_STAGE      = ID,
    parameter int REDIRECT_STAGE = EX,
    parameter int MEM_STAGE      = MEM,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  ctrl
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_cnt_o [PERF_NUM]
`endif
);
    localparam int unsigned HAZ_U   = HAZ_STAGE;
    localparam int unsigned RED_U   = REDIRECT_STAGE;
    localparam int unsigned MEM_U   = MEM_STAGE;
    localparam int          CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(MEM_TIMEOUT);

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [NUM_STAGES-1:0] en, flush;
    logic                  fetch_on;
    logic                  stall_dmem, stall_lu, stall_imem, redir_take;
    logic                  pc_en, pc_sel;
    stall_cause_e          cause;
    int unsigned           frz;
    logic [CNT_W-1:0]      to_cnt_q;
    logic                  to_flag_q;

    // Stall priority: dmem > load-use > imem. An honoured redirect suppresses
    // load-use/imem stalls since the instructions involved are being flushed.
    always_comb begin
        fetch_on   = valid_q[0];
        stall_dmem = fetch_on & valid_q[MEM_STAGE] & ctrl.dmem_busy_i;
        stall_lu   = fetch_on & valid_q[HAZ_STAGE] & ctrl.load_use_i & ~stall_dmem;
        stall_imem = fetch_on & ~ctrl.imem_ready_i & ~stall_dmem & ~stall_lu;
        redir_take = fetch_on & ctrl.redirect_i & ~stall_dmem;

        cause = STALL_NONE;
        if (stall_dmem) begin
            cause = STALL_DMEM;
        end else if (!redir_take) begin
            if (stall_lu)        cause = STALL_LOADUSE;
            else if (stall_imem) cause = STALL_IMEM;
        end
        frz = freeze_index(cause, HAZ_U, MEM_U);
    end

    always_comb begin
        valid_d = valid_q;
        en      = '0;
        flush   = '0;
        pc_en   = 1'b0;
        pc_sel  = 1'b0;
        if (!fetch_on) begin
            // First cycle after reset: no fetch yet, just switch fetch on.
            valid_d[0] = 1'b1;
        end else begin
            pc_en  = (cause == STALL_NONE);
            pc_sel = redir_take;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                if (redir_take && k <= RED_U) begin
                    en[k]      = 1'b1;
                    flush[k]   = 1'b1;
                    valid_d[k] = 1'b0;
                end else if (cause != STALL_NONE && k <= frz) begin
                    en[k] = 1'b0;
                end else if (cause != STALL_NONE && k == frz + 1) begin
                    en[k]      = 1'b1;
                    flush[k]   = 1'b1;
                    valid_d[k] = 1'b0;
                end else begin
                    en[k]      = 1'b1;
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Consecutive dmem-stall cycles, saturating at MEM_TIMEOUT; the flag is
    // raised on the edge where the count reaches MEM_TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else if (stall_dmem) begin
            if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
            if (MEM_TIMEOUT != 0 && to_cnt_q == TO_MAX - 1'b1) to_flag_q <= 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign ctrl.pc_en_o           = pc_en;
    assign ctrl.pc_sel_redirect_o = pc_sel;
    assign ctrl.stage_valid_o     = valid_q;
    assign ctrl.stage_en_o        = en;
    assign ctrl.stage_flush_o     = flush;
    assign ctrl.retire_o          = valid_q[NUM_STAGES-1];
    assign ctrl.mem_timeout_o     = to_flag_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    pipe_perf_cnt u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .retire_i   (valid_q[NUM_STAGES-1]),
        .redirect_i (redir_take),
        .cause_i    (cause),
        .cnt_o      (perf_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (5 stages, MEM_TIMEOUT=4).
// A directed vector table covers reset release, load-use, dmem stall,
// redirect under dmem stall, imem miss and timeout; hand sequences cover
// asynchronous reset mid-stall; random stimulus is checked against an
// instruction-token model of the pipeline.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int NS = 5;
    localparam int HZ = 1;
    localparam int RS = 2;
    localparam int MS = 3;
    localparam int MT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.NUM_STAGES(NS)) bus ();

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] perf_cnt [PERF_NUM];
`endif

    pipe_ctrl #(
        .NUM_STAGES     (NS),
        .HAZ_STAGE      (HZ),
        .REDIRECT_STAGE (RS),
        .MEM_STAGE      (MS),
        .MEM_TIMEOUT    (MT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .perf_cnt_o (perf_cnt)
`endif
    );

    typedef struct packed {
        logic [NS-1:0] valid;
        logic [NS-1:0] en;
        logic [NS-1:0] flush;
        logic          pc_en;
        logic          pc_sel;
        logic          retire;
        logic          timeout;
    } obs_t;

    typedef struct {
        logic imem, dmem, lu, redir;
        obs_t exp;
    } vec_t;

    vec_t tbl[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Token model: slot[k] = id of the instruction in register k, 0 = bubble.
    int   slot[NS];
    bit   fetch_on;
    int   next_id;
    int   busy_run;
    bit   to_flag;

    function automatic obs_t sample();
        obs_t o;
        o = {bus.stage_valid_o, bus.stage_en_o, bus.stage_flush_o, bus.pc_en_o,
             bus.pc_sel_redirect_o, bus.retire_o, bus.mem_timeout_o};
        return o;
    endfunction

    task automatic compare(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got v=%b en=%b fl=%b pc_en=%b sel=%b ret=%b to=%b | want v=%b en=%b fl=%b pc_en=%b sel=%b ret=%b to=%b",
                     name, act.valid, act.en, act.flush, act.pc_en, act.pc_sel, act.retire, act.timeout,
                     exp.valid, exp.en, exp.flush, exp.pc_en, exp.pc_sel, exp.retire, exp.timeout);
        end
    endtask

    task automatic drive(input logic im, input logic dm, input logic lu, input logic rd);
        bus.imem_ready_i = im;
        bus.dmem_busy_i  = dm;
        bus.load_use_i   = lu;
        bus.redirect_i   = rd;
    endtask

    task automatic add(input logic im, input logic dm, input logic lu, input logic rd,
                       input logic [NS-1:0] v, input logic [NS-1:0] en, input logic [NS-1:0] fl,
                       input logic pc, input logic ps, input logic rt, input logic to);
        vec_t r;
        r.imem = im; r.dmem = dm; r.lu = lu; r.redir = rd;
        r.exp  = {v, en, fl, pc, ps, rt, to};
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) slot[k] = 0;
        fetch_on = 1'b0;
        next_id  = 1;
        busy_run = 0;
        to_flag  = 1'b0;
    endtask

    // Returns the outputs expected this cycle, then advances one clock.
    task automatic model_step(input logic im, input logic dm, input logic lu, input logic rd,
                              output obs_t e);
        int nxt[NS];
        bit d, l, i, r, st;
        int f;
        e         = '0;
        e.timeout = to_flag;
        e.valid[0] = fetch_on;
        for (int k = 1; k < NS; k++) e.valid[k] = (slot[k] != 0);
        e.retire = (slot[NS-1] != 0);
        if (!fetch_on) begin
            fetch_on = 1'b1;
            busy_run = 0;
            return;
        end
        d  = (slot[MS] != 0) && dm;
        l  = (slot[HZ] != 0) && lu && !d;
        i  = !im && !d && !l;
        r  = rd && !d;
        st = !r && (d || l || i);
        f  = d ? MS : (l ? HZ : 0);
        e.pc_en  = !st;
        e.pc_sel = r;
        for (int k = 1; k < NS; k++) begin
            if (st && k <= f) begin
                nxt[k] = slot[k];
            end else begin
                e.en[k] = 1'b1;
                if ((r && k <= RS) || (st && k == f + 1)) begin
                    nxt[k]     = 0;
                    e.flush[k] = 1'b1;
                end else if (k == 1) begin
                    nxt[k]  = next_id;
                    next_id = next_id + 1;
                end else begin
                    nxt[k] = slot[k-1];
                end
            end
        end
        for (int k = 1; k < NS; k++) slot[k] = nxt[k];
        if (d) begin
            if (busy_run < MT) busy_run = busy_run + 1;
            if (busy_run == MT) to_flag = 1'b1;
        end else begin
            busy_run = 0;
        end
    endtask

    initial begin
        obs_t e;
        logic im, dm, lu, rd;
        int   burst;

        //   im dm lu rd   valid     en        flush    pc ps rt to
        add(1, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0); // 0 reset release
        add(1, 0, 0, 0, 5'b00001, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 0, 0, 0, 5'b00011, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 0, 0, 0, 5'b00111, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 0, 0, 0, 5'b01111, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 0, 0, 0, 5'b11111, 5'b11110, 5'b00000, 1, 0, 1, 0); // 5 full
        add(1, 0, 1, 0, 5'b11111, 5'b11100, 5'b00100, 0, 0, 1, 0); // 6 load-use
        add(1, 0, 0, 0, 5'b11011, 5'b11110, 5'b00000, 1, 0, 1, 0);
        add(1, 0, 0, 0, 5'b10111, 5'b11110, 5'b00000, 1, 0, 1, 0);
        add(1, 0, 0, 0, 5'b01111, 5'b11110, 5'b00000, 1, 0, 0, 0); // 9 missing retire
        add(1, 1, 0, 0, 5'b11111, 5'b10000, 5'b10000, 0, 0, 1, 0); // 10 dmem x3
        add(1, 1, 0, 0, 5'b01111, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 1, 0, 0, 5'b01111, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 0, 0, 0, 5'b01111, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 1, 0, 1, 5'b11111, 5'b10000, 5'b10000, 0, 0, 1, 0); // 14 redirect held off
        add(1, 1, 0, 1, 5'b01111, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 0, 0, 1, 5'b01111, 5'b11110, 5'b00110, 1, 1, 0, 0); // 16 redirect taken
        add(1, 0, 0, 0, 5'b11001, 5'b11110, 5'b00000, 1, 0, 1, 0);
        add(1, 0, 0, 0, 5'b10011, 5'b11110, 5'b00000, 1, 0, 1, 0);
        add(1, 0, 0, 0, 5'b00111, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(1, 0, 0, 0, 5'b01111, 5'b11110, 5'b00000, 1, 0, 0, 0);
        add(0, 0, 0, 0, 5'b11111, 5'b11110, 5'b00010, 0, 0, 1, 0); // 21 imem miss
        add(1, 0, 0, 0, 5'b11101, 5'b11110, 5'b00000, 1, 0, 1, 0);
        add(1, 1, 0, 0, 5'b11011, 5'b10000, 5'b10000, 0, 0, 1, 0); // 23 dmem x6
        add(1, 1, 0, 0, 5'b01011, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 1, 0, 0, 5'b01011, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 1, 0, 0, 5'b01011, 5'b10000, 5'b10000, 0, 0, 0, 0);
        add(1, 1, 0, 0, 5'b01011, 5'b10000, 5'b10000, 0, 0, 0, 1); // 27 timeout set
        add(1, 1, 0, 0, 5'b01011, 5'b10000, 5'b10000, 0, 0, 0, 1);
        add(1, 0, 0, 0, 5'b01011, 5'b11110, 5'b00000, 1, 0, 0, 1); // 29 sticky
        add(1, 0, 0, 0, 5'b10111, 5'b11110, 5'b00000, 1, 0, 1, 1);

        drive(1, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].imem, tbl[i].dmem, tbl[i].lu, tbl[i].redir);
            #1 compare($sformatf("tbl[%0d]", i), tbl[i].exp);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a dmem stall.
        drive(1, 1, 0, 0);
        #1 compare("stall_before_reset", {5'b01111, 5'b10000, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1});
        #1 rst_n = 1'b0;
        #1 compare("reset_mid_stall", '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        #1 compare("restart_cycle0", '0);
        @(negedge clk);
        #1 compare("restart_cycle1", {5'b00001, 5'b11110, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);

        // Random stimulus against the token model, with one reset midway.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        burst = 0;
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                drive(1, 1, 0, 0);
                #1 rst_n = 1'b0;
                #1 compare("rand_async_reset", '0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                burst = 0;
            end
            im = ($urandom_range(0, 99) < 85);
            if (burst > 0) begin
                dm    = 1'b1;
                burst = burst - 1;
            end else if ($urandom_range(0, 99) < 10) begin
                dm    = 1'b1;
                burst = $urandom_range(0, 6);
            end else begin
                dm = 1'b0;
            end
            lu = ($urandom_range(0, 99) < 15);
            rd = ($urandom_range(0, 99) < 10);
            drive(im, dm, lu, rd);
            model_step(im, dm, lu, rd, e);
            #1 compare($sformatf("rand[%0d]", n), e);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
